// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles PS/2 mouse bytes into packets, reports deltas/buttons and keeps a
// clamped absolute cursor. Define MOUSE_WHEEL_EN for 4-byte IntelliMouse packets.
module ps2_mouse_packet_decoder #(
   parameter int TIMEOUT_CYCLES = 100000000,
   parameter int X_W            = 10,
   parameter int Y_W            = 9,
   parameter int X_MAX          = 639,
   parameter int Y_MAX          = 479,
   parameter int X_INIT         = 320,
   parameter int Y_INIT         = 240
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           byte_valid,
   input  logic [7:0]     byte_data,
   output logic           pkt_valid,
   output logic [8:0]     dx,
   output logic [8:0]     dy,
   output logic [3:0]     dz,
   output logic [2:0]     btn,
   output logic           left_click,
   output logic [1:0]     ovf,
   output logic [X_W-1:0] pos_x,
   output logic [Y_W-1:0] pos_y,
   output logic           sync_err,
   output logic           timeout
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]         T_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic signed [X_W+1:0] X_MAX_S = (X_W+2)'(X_MAX);
   localparam logic signed [Y_W+1:0] Y_MAX_S = (Y_W+2)'(Y_MAX);

   typedef enum logic [1:0] {
      S_B0 = 2'd0,
      S_B1 = 2'd1,
      S_B2 = 2'd2
`ifdef MOUSE_WHEEL_EN
      , S_B3 = 2'd3
`endif
   } state_t;

   function automatic logic [X_W-1:0] clamp_x(input logic signed [X_W+1:0] v);
      if (v[X_W+1]) begin
         clamp_x = '0;
      end else if (v > X_MAX_S) begin
         clamp_x = X_W'(X_MAX);
      end else begin
         clamp_x = v[X_W-1:0];
      end
   endfunction

   function automatic logic [Y_W-1:0] clamp_y(input logic signed [Y_W+1:0] v);
      if (v[Y_W+1]) begin
         clamp_y = '0;
      end else if (v > Y_MAX_S) begin
         clamp_y = Y_W'(Y_MAX);
      end else begin
         clamp_y = v[Y_W-1:0];
      end
   endfunction

   state_t        state_r, state_nxt_s;
   logic [TW-1:0] timer_r, timer_nxt_s;
   logic          cap0_s, cap1_s, done_s, sync_err_s, timeout_s;
`ifdef MOUSE_WHEEL_EN
   logic          cap2_s;
   logic [7:0]    b2_r;
`endif

   // byte 0 is kept as named fields; its sync bit carries no information
   logic [2:0]    b0_btn_r;
   logic          x_sign_r, y_sign_r, x_ovf_r, y_ovf_r;
   logic [7:0]    b1_r;

   logic [7:0]    b2_s;
   logic [3:0]    dz_s;
   logic [8:0]    dx_s, dy_s;
   logic signed [X_W+1:0] dx_add_s, nx_s;
   logic signed [Y_W+1:0] dy_sub_s, ny_s;
   logic [X_W-1:0] pos_x_nxt_s;
   logic [Y_W-1:0] pos_y_nxt_s;

   logic           pkt_valid_r, left_click_r, sync_err_r, timeout_r;
   logic [8:0]     dx_r, dy_r;
   logic [3:0]     dz_r;
   logic [2:0]     btn_r;
   logic [1:0]     ovf_r;
   logic [X_W-1:0] pos_x_r;
   logic [Y_W-1:0] pos_y_r;

   // packet FSM next-state, inter-byte timer and event decode
   always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      cap0_s      = 1'b0;
      cap1_s      = 1'b0;
`ifdef MOUSE_WHEEL_EN
      cap2_s      = 1'b0;
`endif
      done_s      = 1'b0;
      sync_err_s  = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         S_B0: begin
            timer_nxt_s = '0;
            if (byte_valid) begin
               if (byte_data[3]) begin
                  cap0_s      = 1'b1;
                  state_nxt_s = S_B1;
               end else begin
                  sync_err_s  = 1'b1;
                  state_nxt_s = S_B0;
               end
            end else begin
               state_nxt_s = S_B0;
            end
         end
         S_B1: begin
            if (byte_valid) begin
               cap1_s      = 1'b1;
               timer_nxt_s = '0;
               state_nxt_s = S_B2;
            end else if (timer_r == T_LAST) begin
               timeout_s   = 1'b1;
               timer_nxt_s = '0;
               state_nxt_s = S_B0;
            end else begin
               timer_nxt_s = timer_r + TW'(1);
            end
         end
         S_B2: begin
            if (byte_valid) begin
               timer_nxt_s = '0;
`ifdef MOUSE_WHEEL_EN
               cap2_s      = 1'b1;
               state_nxt_s = S_B3;
`else
               done_s      = 1'b1;
               state_nxt_s = S_B0;
`endif
            end else if (timer_r == T_LAST) begin
               timeout_s   = 1'b1;
               timer_nxt_s = '0;
               state_nxt_s = S_B0;
            end else begin
               timer_nxt_s = timer_r + TW'(1);
            end
         end
`ifdef MOUSE_WHEEL_EN
         S_B3: begin
            if (byte_valid) begin
               done_s      = 1'b1;
               timer_nxt_s = '0;
               state_nxt_s = S_B0;
            end else if (timer_r == T_LAST) begin
               timeout_s   = 1'b1;
               timer_nxt_s = '0;
               state_nxt_s = S_B0;
            end else begin
               timer_nxt_s = timer_r + TW'(1);
            end
         end
`endif
         default: begin
            state_nxt_s = S_B0;
            timer_nxt_s = '0;
         end
      endcase
   end

   // FSM state and timer registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= S_B0;
         timer_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         timer_r <= timer_nxt_s;
      end
   end

   // byte capture registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         b0_btn_r <= 3'd0;
         x_sign_r <= 1'b0;
         y_sign_r <= 1'b0;
         x_ovf_r  <= 1'b0;
         y_ovf_r  <= 1'b0;
         b1_r     <= 8'd0;
`ifdef MOUSE_WHEEL_EN
         b2_r     <= 8'd0;
`endif
      end else begin
         if (cap0_s) begin
            b0_btn_r <= byte_data[2:0];
            x_sign_r <= byte_data[4];
            y_sign_r <= byte_data[5];
            x_ovf_r  <= byte_data[6];
            y_ovf_r  <= byte_data[7];
         end
         if (cap1_s) begin
            b1_r <= byte_data;
         end
`ifdef MOUSE_WHEEL_EN
         if (cap2_s) begin
            b2_r <= byte_data;
         end
`endif
      end
   end

   // packet fields and next cursor; the final byte is taken straight from byte_data
   always_comb begin
`ifdef MOUSE_WHEEL_EN
      b2_s = b2_r;
      dz_s = byte_data[3:0];
`else
      b2_s = byte_data;
      dz_s = 4'd0;
`endif
      dx_s = {x_sign_r, b1_r};
      dy_s = {y_sign_r, b2_s};
      if (x_ovf_r) begin
         dx_add_s = '0;
      end else begin
         dx_add_s = {{(X_W-7){dx_s[8]}}, dx_s};
      end
      if (y_ovf_r) begin
         dy_sub_s = '0;
      end else begin
         dy_sub_s = {{(Y_W-7){dy_s[8]}}, dy_s};
      end
      nx_s        = $signed({2'b00, pos_x_r}) + dx_add_s;
      ny_s        = $signed({2'b00, pos_y_r}) - dy_sub_s;
      pos_x_nxt_s = clamp_x(nx_s);
      pos_y_nxt_s = clamp_y(ny_s);
   end

   // registered outputs: pulses every cycle, packet fields only on completion
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pkt_valid_r  <= 1'b0;
         left_click_r <= 1'b0;
         sync_err_r   <= 1'b0;
         timeout_r    <= 1'b0;
         dx_r         <= 9'd0;
         dy_r         <= 9'd0;
         dz_r         <= 4'd0;
         btn_r        <= 3'd0;
         ovf_r        <= 2'd0;
         pos_x_r      <= X_W'(X_INIT);
         pos_y_r      <= Y_W'(Y_INIT);
      end else begin
         pkt_valid_r  <= done_s;
         sync_err_r   <= sync_err_s;
         timeout_r    <= timeout_s;
         left_click_r <= 1'b0;
         if (done_s) begin
            dx_r         <= dx_s;
            dy_r         <= dy_s;
            dz_r         <= dz_s;
            btn_r        <= b0_btn_r;
            ovf_r        <= {y_ovf_r, x_ovf_r};
            left_click_r <= b0_btn_r[0] & ~btn_r[0];
            pos_x_r      <= pos_x_nxt_s;
            pos_y_r      <= pos_y_nxt_s;
         end
      end
   end

   assign pkt_valid  = pkt_valid_r;
   assign left_click = left_click_r;
   assign sync_err   = sync_err_r;
   assign timeout    = timeout_r;
   assign dx         = dx_r;
   assign dy         = dy_r;
   assign dz         = dz_r;
   assign btn        = btn_r;
   assign ovf        = ovf_r;
   assign pos_x      = pos_x_r;
   assign pos_y      = pos_y_r;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Scoreboard bench for ps2_mouse_packet_decoder: directed cases from the test
// plan plus a randomized byte stream against a packet-level reference model.
module tb_ps2_mouse_packet_decoder;

   localparam int T = 16;
`ifdef MOUSE_WHEEL_EN
   localparam int NB = 4;
`else
   localparam int NB = 3;
`endif
   localparam int K_PKT  = 0;
   localparam int K_SYNC = 1;
   localparam int K_TO   = 2;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'd0;
   logic       pkt_valid, left_click, sync_err, timeout;
   logic [8:0] dx, dy;
   logic [3:0] dz;
   logic [2:0] btn;
   logic [1:0] ovf;
   logic [9:0] pos_x;
   logic [8:0] pos_y;

   ps2_mouse_packet_decoder #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rstn(rstn), .byte_valid(byte_valid), .byte_data(byte_data),
      .pkt_valid(pkt_valid), .dx(dx), .dy(dy), .dz(dz), .btn(btn),
      .left_click(left_click), .ovf(ovf), .pos_x(pos_x), .pos_y(pos_y),
      .sync_err(sync_err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int kind;
      int dx, dy, dz, btn, lc, ovf, px, py;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   // reference model state: bytes of the packet in progress and cursor
   logic [7:0] mb[4];
   int n, mpx, mpy, mprev_left;

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      n = 0; mpx = 320; mpy = 240; mprev_left = 0;
      q.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      exp_t e;
      logic [3:0] w;
      e = '0;
      if (n == 0) begin
         if (b[3]) begin
            mb[0] = b; n = 1;
         end else begin
            e.kind = K_SYNC; q.push_back(e);
         end
      end else begin
         mb[n] = b; n++;
         if (n == NB) begin
            e.kind = K_PKT;
            e.dx   = int'(mb[1]) - (mb[0][4] ? 256 : 0);
            e.dy   = int'(mb[2]) - (mb[0][5] ? 256 : 0);
            w      = mb[3][3:0];
            e.dz   = (NB == 4) ? ((int'(w) >= 8) ? int'(w) - 16 : int'(w)) : 0;
            e.btn  = int'(mb[0][2:0]);
            e.lc   = (mb[0][0] && mprev_left == 0) ? 1 : 0;
            e.ovf  = int'(mb[0][7]) * 2 + int'(mb[0][6]);
            mprev_left = int'(mb[0][0]);
            if (!mb[0][6]) mpx = clampi(mpx + e.dx, 639);
            if (!mb[0][7]) mpy = clampi(mpy - e.dy, 479);
            e.px = mpx; e.py = mpy;
            q.push_back(e);
            n = 0;
         end
      end
   endtask

   task automatic model_gap(input int gap);
      exp_t e;
      e = '0;
      if (n > 0 && gap >= T) begin
         e.kind = K_TO; q.push_back(e); n = 0;
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      model_byte(b);
      model_gap(gap);
      byte_data = b; byte_valid = 1'b1;
      @(posedge clk); #1;
      byte_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0; byte_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      model_reset();
   endtask

   // monitor: every output event is popped and compared against the model
   always @(negedge clk) begin
      exp_t e;
      int k;
      if (rstn && (pkt_valid || sync_err || timeout)) begin
         vectors++;
         k = pkt_valid ? K_PKT : (sync_err ? K_SYNC : K_TO);
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d (pv=%b se=%b to=%b) expected none",
                     k, pkt_valid, sync_err, timeout);
         end else begin
            e = q.pop_front();
            if ((int'(pkt_valid) + int'(sync_err) + int'(timeout)) != 1 || k != e.kind ||
                (k == K_PKT && (int'($signed(dx)) != e.dx || int'($signed(dy)) != e.dy ||
                 int'($signed(dz)) != e.dz || int'(btn) != e.btn || int'(left_click) != e.lc ||
                 int'(ovf) != e.ovf || int'(pos_x) != e.px || int'(pos_y) != e.py))) begin
               miscompares++;
               $display("FAIL event: got kind=%0d pv=%b se=%b to=%b dx=%0d dy=%0d dz=%0d btn=%0d lc=%0d ovf=%0d px=%0d py=%0d expected kind=%0d dx=%0d dy=%0d dz=%0d btn=%0d lc=%0d ovf=%0d px=%0d py=%0d",
                        k, pkt_valid, sync_err, timeout, $signed(dx), $signed(dy), $signed(dz),
                        btn, left_click, ovf, pos_x, pos_y, e.kind, e.dx, e.dy, e.dz, e.btn,
                        e.lc, e.ovf, e.px, e.py);
            end
         end
      end
   end

   initial begin
      logic [7:0] rb;
      int r, gap;

      do_reset();
      check("rst_pkt_valid", int'(pkt_valid), 0);
      check("rst_dx", int'(dx), 0);
      check("rst_btn", int'(btn), 0);
      check("rst_pos_x", int'(pos_x), 320);
      check("rst_pos_y", int'(pos_y), 240);

      // basic packet
      send(8'h08, 0); send(8'h05, 0); send(8'h03, 0);
`ifndef MOUSE_WHEEL_EN
      check("p1_pkt_valid", int'(pkt_valid), 1);
      check("p1_pos_x", int'(pos_x), 325);
      check("p1_pos_y", int'(pos_y), 237);
      check("p1_dx", int'($signed(dx)), 5);
`else
      send(8'h00, 0);
`endif

      // left press with negative deltas, then the same packet again
      send(8'h39, 0); send(8'hF6, 0); send(8'hFE, 0);
`ifdef MOUSE_WHEEL_EN
      send(8'h00, 0);
`endif
      check("p2_left_click", int'(left_click), 1);
      check("p2_dx", int'($signed(dx)), -10);
      send(8'h39, 0); send(8'hF6, 0); send(8'hFE, 0);
`ifdef MOUSE_WHEEL_EN
      send(8'h00, 0);
`endif
      check("p3_left_click", int'(left_click), 0);
      check("p3_btn", int'(btn), 1);

      // sync error then a good packet
      send(8'h00, 0);
      check("sync_err_pulse", int'(sync_err), 1);
      send(8'h08, 0); send(8'h01, 0); send(8'h01, 2);
`ifdef MOUSE_WHEEL_EN
      send(8'h00, 2);
`endif

      // timeout, then a byte arriving exactly at expiry is accepted
      send(8'h08, T);
      check("timeout_pulse", int'(timeout), 1);
      send(8'h08, T - 1); send(8'h01, 0); send(8'h01, 2);
`ifdef MOUSE_WHEEL_EN
      send(8'h00, 2);
`endif

      // X clamp at X_MAX and overflowed axis
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(8'h08, 0); send((i == 3) ? 8'd10 : 8'd100, 0); send(8'h00, 0);
`ifdef MOUSE_WHEEL_EN
         send(8'h00, 0);
`endif
      end
      check("clamp_pos_x", int'(pos_x), 639);
      send(8'h48, 0); send(8'h7F, 0); send(8'h00, 0);
`ifdef MOUSE_WHEEL_EN
      send(8'h00, 0);
`endif
      check("ovf_bits", int'(ovf), 1);
      check("ovf_pos_x", int'(pos_x), 639);
      check("ovf_dx", int'($signed(dx)), 127);

      // reset mid-packet
      send(8'h08, 0); send(8'h20, 0);
      do_reset();
      check("midrst_pos_x", int'(pos_x), 320);
      send(8'h08, 0); send(8'h02, 0); send(8'h00, 0);
`ifdef MOUSE_WHEEL_EN
      check("wheel_no_early_pv", int'(pkt_valid), 0);
      send(8'h0F, 0);
      check("wheel_dz", int'($signed(dz)), -1);
      send(8'h08, 0); send(8'h00, 0); send(8'h00, 0); send(8'h0F, 0);
`endif
      check("after_rst_pos_x", int'(pos_x), 322);

      // randomized stream
      for (int i = 0; i < 600; i++) begin
         rb = 8'($urandom_range(0, 255));
         if (n == 0 && $urandom_range(0, 9) < 8) rb[3] = 1'b1;
         r = $urandom_range(0, 99);
         if (r < 4) gap = T + $urandom_range(0, 4);
         else if (r < 8) gap = T - 1;
         else gap = $urandom_range(0, 2);
         send(rb, gap);
      end
      model_gap(T + 4);
      repeat (T + 4) @(posedge clk);

      for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
      #1;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d events outstanding expected 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
